// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } pc_state_e;

  localparam logic [31:0] INSTR_BYTES  = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0040_0004;

  // Word-align a byte address (low two bits are not meaningful for fetch).
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bus: instruction memory request/ack plus decode valid/ready.
// Latency: n/a (wiring only).
// Backpressure: decode stalls issue by holding instr_ready low.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/pc_en_reg.sv
// 32-bit register with synchronous reset to a fixed value and a load enable.
// Latency: 1 cycle from d/en to q.
// Backpressure: none; holds value while en is low.
module pc_en_reg #(
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // Load on enable, otherwise hold; reset wins.
  always_ff @(posedge clk) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the PC: fetches from imem, holds the word for decode, advances by 4 on consume, applies redirect/halt.
// Latency: reset release -> req next cycle; zero-wait ack -> instr_valid the cycle after; peak 1 instr / 2 cycles.
// Backpressure: ISSUE holds instr/instr_pc stable until instr_ready; FETCH holds imem_addr until imem_ack.
// Optional trap support (trap input, epc output) is enabled by defining PC_SEQ_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef PC_SEQ_TRAP_EN
  , parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
`endif
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus,
  input  logic           redir_valid,
  input  logic [31:0]    redir_pc,
  input  logic           halt,
  output logic [31:0]    pc
`ifdef PC_SEQ_TRAP_EN
  , input  logic         trap
  , output logic [31:0]  epc
`endif
);

  pc_state_e   state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_en;
  logic [31:0] redir_tgt;
  logic        unused_redir_lsb;

  assign redir_tgt        = word_align(redir_pc);
  assign unused_redir_lsb = ^redir_pc[1:0];

  pc_en_reg #(.RST_VAL(RESET_PC)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc_q)
  );

`ifdef PC_SEQ_TRAP_EN
  logic [31:0] epc_q, epc_d;
`endif

  // Next-state, next-pc and held-instruction logic.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    pc_d       = pc_q;
    pc_en      = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = halt ? HALT : FETCH;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          if (redir_valid || pend_q) begin
            // Word fetched from a stale address: drop it and refetch at the target.
            pc_d   = redir_valid ? redir_tgt : pend_pc_q;
            pc_en  = 1'b1;
            pend_d = 1'b0;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            state_d    = ISSUE;
          end
        end else if (redir_valid) begin
          // Request already on the bus; remember the target until it completes.
          pend_d    = 1'b1;
          pend_pc_d = redir_tgt;
        end
      end
      ISSUE: begin
        if (redir_valid) begin
          pc_d    = redir_tgt;
          pc_en   = 1'b1;
          state_d = FETCH;
        end else if (bus.instr_ready) begin
          pc_d    = pc_q + INSTR_BYTES;
          pc_en   = 1'b1;
          state_d = halt ? HALT : FETCH;
        end
      end
      HALT: begin
        if (redir_valid) begin
          pc_d    = redir_tgt;
          pc_en   = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PC_SEQ_TRAP_EN
    epc_d = epc_q;
    // Trap overrides everything decided above.
    if (trap) begin
      epc_d = (state_q == ISSUE) ? instr_pc_q : pc_q;
      if (state_q == FETCH && !bus.imem_ack) begin
        pend_d    = 1'b1;
        pend_pc_d = TRAP_VEC;
        pc_d      = pc_q;
        pc_en     = 1'b0;
      end else begin
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pend_d     = 1'b0;
        pc_d       = TRAP_VEC;
        pc_en      = 1'b1;
        state_d    = FETCH;
      end
    end
`endif
  end

  // State and held-instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      pend_q     <= 1'b0;
      pend_pc_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

`ifdef PC_SEQ_TRAP_EN
  // Exception PC register.
  always_ff @(posedge clk) begin
    if (rst) epc_q <= 32'h0;
    else     epc_q <= epc_d;
  end
  assign epc = epc_q;
`endif

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == ISSUE);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign pc              = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a scoreboard of expected issued instructions.
// Latency: n/a.
// Backpressure: drives instr_ready low to exercise ISSUE hold.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        halt;
  logic [31:0] pc;
  logic        trap;
`ifdef PC_SEQ_TRAP_EN
  logic [31:0] epc;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } sb_ent_t;
  sb_ent_t sb_q[$];

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .halt        (halt),
    .pc          (pc)
`ifdef PC_SEQ_TRAP_EN
    , .trap      (trap)
    , .epc       (epc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model follows the current address; advance one cycle and settle.
  task automatic tick();
    bus.imem_rdata = mem_word(bus.imem_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a);
    sb_ent_t e;
    e.addr = a;
    e.word = mem_word(a);
    sb_q.push_back(e);
  endtask

  // Decode-side monitor: consumed instructions are compared, dropped ones discarded.
  always @(negedge clk) begin
    if (!rst && bus.instr_valid && (redir_valid || trap)) begin
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end else if (!rst && bus.instr_valid && bus.instr_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        sb_ent_t e;
        e = sb_q.pop_front();
        check("issue_instr", bus.instr, e.word);
        check("issue_pc", bus.instr_pc, e.addr);
      end
    end
  end

  initial begin
    rst = 1'b1; redir_valid = 1'b0; redir_pc = 32'h0; halt = 1'b0; trap = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
    tick(); tick();
    check("rst_pc", pc, RST_PC);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_vld", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 32'h0);

    // Streaming with zero-wait ack and always-ready decode.
    rst = 1'b0; bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      check("stream_req", 32'(bus.imem_req), 32'd1);
      check("stream_addr", bus.imem_addr, RST_PC + 32'(4 * i));
      push_fetch(bus.imem_addr);
      tick();
      check("stream_vld", 32'(bus.instr_valid), 32'd1);
      check("stream_noreq", 32'(bus.imem_req), 32'd0);
      tick();
    end

    // Decode stall at 0x00400008.
    check("stall_addr", bus.imem_addr, 32'h0040_0008);
    push_fetch(bus.imem_addr);
    bus.instr_ready = 1'b0;
    tick();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_vld", 32'(bus.instr_valid), 32'd1);
      check("stall_instr", bus.instr, mem_word(32'h0040_0008));
      check("stall_instr_pc", bus.instr_pc, 32'h0040_0008);
      check("stall_pc", pc, 32'h0040_0008);
      check("stall_noreq", 32'(bus.imem_req), 32'd0);
      tick();
    end
    bus.instr_ready = 1'b1;
    tick();
    check("after_stall_addr", bus.imem_addr, 32'h0040_000C);

    // Redirect during an outstanding fetch; ack two cycles later is discarded.
    redir_valid = 1'b1; redir_pc = 32'h0040_1003;
    tick();
    redir_valid = 1'b0;
    check("pend_hold_addr", bus.imem_addr, 32'h0040_000C);
    tick();
    bus.imem_ack = 1'b1;
    tick();
    check("pend_new_addr", bus.imem_addr, 32'h0040_1000);
    check("pend_no_vld", 32'(bus.instr_valid), 32'd0);
    check("pend_req", 32'(bus.imem_req), 32'd1);
    push_fetch(bus.imem_addr);
    tick();
    check("redir_fetch_vld", 32'(bus.instr_valid), 32'd1);

    // Redirect together with instr_ready in ISSUE drops the instruction.
    redir_valid = 1'b1; redir_pc = 32'h0040_0010;
    tick();
    redir_valid = 1'b0;
    check("drop_vld", 32'(bus.instr_valid), 32'd0);
    check("drop_addr", bus.imem_addr, 32'h0040_0010);
    check("drop_req", 32'(bus.imem_req), 32'd1);

    // Halt on consumption at 0x00400010, then resume by redirect.
    push_fetch(bus.imem_addr);
    tick();
    halt = 1'b1;
    tick();
    check("halt_pc", pc, 32'h0040_0014);
    check("halt_noreq", 32'(bus.imem_req), 32'd0);
    tick();
    check("halt_noreq2", 32'(bus.imem_req), 32'd0);
    check("halt_novld", 32'(bus.instr_valid), 32'd0);
    redir_valid = 1'b1; redir_pc = 32'h0040_0100;
    tick();
    redir_valid = 1'b0; halt = 1'b0;
    check("resume_addr", bus.imem_addr, 32'h0040_0100);
    check("resume_req", 32'(bus.imem_req), 32'd1);

    // Same-cycle redirect beats a pending one.
    bus.imem_ack = 1'b0; redir_valid = 1'b1; redir_pc = 32'h0050_0000;
    tick();
    bus.imem_ack = 1'b1; redir_pc = 32'h0060_0000;
    tick();
    redir_valid = 1'b0;
    check("pend_override", bus.imem_addr, 32'h0060_0000);

    // PC wrap at the top of the address space.
    redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    push_fetch(bus.imem_addr);
    tick();
    tick();
    check("wrap_pc", pc, 32'h0);

`ifdef PC_SEQ_TRAP_EN
    // Trap in ISSUE saves the instruction address and vectors.
    redir_valid = 1'b1; redir_pc = 32'h0040_0020;
    tick();
    redir_valid = 1'b0;
    push_fetch(bus.imem_addr);
    tick();
    check("trap_pre_instr_pc", bus.instr_pc, 32'h0040_0020);
    trap = 1'b1; bus.instr_ready = 1'b0;
    tick();
    trap = 1'b0; bus.instr_ready = 1'b1;
    check("trap_epc", epc, 32'h0040_0020);
    check("trap_addr", bus.imem_addr, 32'h0040_0004);
    check("trap_novld", 32'(bus.instr_valid), 32'd0);
`endif

    // Reset during an outstanding fetch; ack in the reset cycle is ignored.
    bus.imem_ack = 1'b0;
    tick();
    check("midrst_pre_req", 32'(bus.imem_req), 32'd1);
    rst = 1'b1; bus.imem_ack = 1'b1;
    tick();
    rst = 1'b0; bus.imem_ack = 1'b0;
    check("midrst_pc", pc, RST_PC);
    check("midrst_noreq", 32'(bus.imem_req), 32'd0);
    check("midrst_novld", 32'(bus.instr_valid), 32'd0);
    tick();
    check("midrst_req", 32'(bus.imem_req), 32'd1);
    check("midrst_addr", bus.imem_addr, RST_PC);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch controller that owns the CPU program counter and sequences it against a single-port instruction memory. It issues fetch requests, holds the fetched word for the decode stage under a valid/ready handshake, advances the PC by 4 on consumption, and applies branch/jump redirects and halt. It sits between the PC register and the decode stage and is the only writer of the PC.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- TRAP_VEC, 32'h0040_0004, trap handler address (used only with PC_SEQ_TRAP_EN)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, **synchronous, active-high**
- imem_req  out  1  fetch request, high only in FETCH
- imem_addr  out  32  fetch address, equals pc
- imem_ack  in  1  memory completes request this cycle; imem_rdata valid
- imem_rdata  in  32  fetched word
- instr_valid  out  1  instr/instr_pc valid, high only in ISSUE
- instr  out  32  held instruction word
- instr_pc  out  32  address of held instruction
- instr_ready  in  1  decode consumes instr when instr_valid & instr_ready
- redir_valid  in  1  branch/jump redirect request
- redir_pc  in  32  redirect target; bits [1:0] ignored
- halt  in  1  stop fetching after current instruction is consumed
- pc  out  32  current PC
- trap  in  1  trap request (PC_SEQ_TRAP_EN only)
- epc  out  32  PC saved on trap (PC_SEQ_TRAP_EN only)

## Operation
- States: IDLE, FETCH, ISSUE, HALT. Reset: state IDLE, pc RESET_PC, instr 0, instr_pc 0, pend 0, pend_pc 0, epc 0; imem_req 0, instr_valid 0.
- pc[1:0] always 0; redir_pc stored as {redir_pc[31:2],2'b00}. pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- IDLE: halt -> HALT, else -> FETCH.
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_ack. redir_valid without ack: pend<=1, pend_pc<=redir_pc (later redirect overwrites earlier). On imem_ack: if pend or redir_valid this cycle, discard imem_rdata, pc<=target (same-cycle redir_pc wins over pend_pc), pend<=0, stay FETCH; else instr<=imem_rdata, instr_pc<=pc, -> ISSUE. halt ignored in FETCH.
- ISSUE: instr_valid=1, instr/instr_pc held stable. redir_valid: instruction dropped (even if instr_ready), pc<=redir_pc, -> FETCH. Else instr_ready: pc<=pc+4, -> HALT if halt else FETCH. Else hold.
- HALT: no request; redir_valid -> pc<=redir_pc, -> FETCH; otherwise remain.
- rst mid-transaction: outstanding request abandoned; imem_ack in reset cycle ignored.

## Timing
- Request-to-ack may be 0 cycles (ack in the same cycle imem_req rises).
- Reset deasserted at edge N: IDLE cycle N, imem_req high cycle N+1; zero-wait ack -> instr_valid high N+2.
- Peak throughput: one instruction per 2 cycles (FETCH, ISSUE alternate).
- Redirect in ISSUE: new address on imem_addr next cycle.
- pc, instr, instr_pc, epc, state registered; imem_req, imem_addr, instr_valid decoded from state/pc only (no input-to-output combinational path).

## Configuration
- PC_SEQ_TRAP_EN defined: trap port and epc present. trap is highest priority in every state: epc<=instr_pc in ISSUE, pc otherwise; target TRAP_VEC. In FETCH without ack it becomes a pending redirect to TRAP_VEC (overrides redir); elsewhere pc<=TRAP_VEC, -> FETCH; leaves HALT.
- Undefined: no trap/epc ports, no trap logic; behaviour otherwise identical.

## Structure
- Package pc_seq_pkg: state enum type (IDLE, FETCH, ISSUE, HALT), INSTR_BYTES=4, default RESET_PC/TRAP_VEC constants.
- One sub-module pc_en_reg: 32-bit register with synchronous active-high reset to parameter value and load enable; instantiated for pc. Sequencer computes next-pc and enable.

## Test plan
- Reset release, imem_ack tied 1, instr_ready tied 1 -> imem_addr 0x00400000, 0x00400004, 0x00400008 on successive FETCH cycles; instr_valid every other cycle.
- ISSUE at 0x00400008 with instr_ready=0 for 3 cycles -> instr, instr_pc stable, pc stays 0x00400008, no imem_req.
- redir_valid with redir_pc=0x00401003 while in FETCH, ack 2 cycles later -> word discarded, next imem_addr 0x00401000, no instr_valid for discarded word.
- redir_valid and instr_ready together in ISSUE -> instruction dropped, pc=redir target, next state FETCH.
- halt with consumption at 0x00400010 -> pc 0x00400014, imem_req stays 0; redir_valid to 0x00400100 -> fetch resumes there. pc at 0xFFFFFFFC consumed -> pc 0.
- PC_SEQ_TRAP_EN: trap in ISSUE with instr_pc 0x00400020 -> epc 0x00400020, next imem_addr 0x00400004; rst mid-FETCH -> pc 0x00400000, imem_req 0 next cycle.
